// File: rtl/cache_pkg.sv
// Shared state encoding and geometry helpers for the set-associative cache controller.
// No logic of its own; nothing here adds latency or backpressure.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_FILL,
    ST_ACCESS
  } state_t;

  function automatic int tag_bits(input int addr_w, input int index_b, input int offset_b);
    return addr_w - index_b - offset_b;
  endfunction

  function automatic int pow2(input int b);
    return 1 << b;
  endfunction

  // A single way still needs a one-bit age/way field so port widths stay non-zero.
  function automatic int age_bits(input int ways);
    return (ways > 2) ? $clog2(ways) : 1;
  endfunction

  function automatic bit ways_legal(input int ways);
    return (ways == 1) || (ways == 2) || (ways == 4);
  endfunction

endpackage

// File: rtl/cache_assoc_ctrl_if.sv
// CPU request and SDRAM word-strobe signals of the cache; master is the CPU/SDRAM side, slave the cache.
// Pure wiring: no latency; the CPU is held off by rdy_cpu, the SDRAM is paced by the cache.
interface cache_assoc_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] Address_cpu;
  logic                  wr_rd_cpu;
  logic                  cs_cpu;
  logic [DATA_WIDTH-1:0] DOut_cpu;
  logic [DATA_WIDTH-1:0] din_cpu;
  logic                  rdy_cpu;
  logic [ADDR_WIDTH-1:0] Address_sdram;
  logic                  wr_rd_sdram;
  logic                  mstrb_sdram;
  logic [DATA_WIDTH-1:0] din_sdram;
  logic [DATA_WIDTH-1:0] DOut_sdram;

  modport master (
    output Address_cpu, wr_rd_cpu, cs_cpu, DOut_cpu, DOut_sdram,
    input  din_cpu, rdy_cpu, Address_sdram, wr_rd_sdram, mstrb_sdram, din_sdram
  );

  modport slave (
    input  Address_cpu, wr_rd_cpu, cs_cpu, DOut_cpu, DOut_sdram,
    output din_cpu, rdy_cpu, Address_sdram, wr_rd_sdram, mstrb_sdram, din_sdram
  );
endinterface

// File: rtl/cache_lru.sv
// True-LRU age update and victim select for one set; purely combinational.
// Zero latency, no backpressure.
module cache_lru
  import cache_pkg::*;
#(
  parameter int WAYS     = 2,
  parameter int AGE_BITS = 1
) (
  input  logic [WAYS-1:0][AGE_BITS-1:0] age_i,
  input  logic [AGE_BITS-1:0]           way_i,
  output logic [WAYS-1:0][AGE_BITS-1:0] age_o,
  output logic [AGE_BITS-1:0]           victim_o
);
  logic [AGE_BITS-1:0] old_age;

  always_comb begin
    old_age  = age_i[way_i];
    age_o    = age_i;
    victim_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_BITS'(w) == way_i) begin
        age_o[w] = '0;
      end else if (age_i[w] < old_age) begin
        age_o[w] = age_i[w] + AGE_BITS'(1);
      end
      if (age_i[w] == AGE_BITS'(WAYS - 1)) begin
        victim_o = AGE_BITS'(w);
      end
    end
  end
endmodule

// File: rtl/cache_assoc_ctrl.sv
// N-way write-back, write-allocate cache with true LRU between a CPU and a word-strobed SDRAM.
// Hit: rdy_cpu low 2 cycles; misses add B*(SDRAM_LAT+1) per block moved; cs_cpu ignored while rdy_cpu is low.
module cache_assoc_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int OFFSET_BITS = 5,
  parameter int INDEX_BITS  = 3,
  parameter int WAYS        = 2,
  parameter int SDRAM_LAT   = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_assoc_ctrl_if.slave    bus,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);
  localparam int TAG_BITS    = tag_bits(ADDR_WIDTH, INDEX_BITS, OFFSET_BITS);
  localparam int BLOCK_WORDS = pow2(OFFSET_BITS);
  localparam int SETS        = pow2(INDEX_BITS);
  localparam int AGE_BITS    = age_bits(WAYS);
  localparam int CYC_BITS    = $clog2(SDRAM_LAT + 1);
  localparam logic [CYC_BITS-1:0] LAT_C = CYC_BITS'(SDRAM_LAT);

  typedef logic [WAYS-1:0][AGE_BITS-1:0] ages_t;
  typedef logic [WAYS-1:0][TAG_BITS-1:0] tags_t;

  if (!ways_legal(WAYS)) begin : g_ways_check
    $error("cache_assoc_ctrl: WAYS must be 1, 2 or 4");
  end

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [AGE_BITS-1:0]   way_q, way_d;
  logic [OFFSET_BITS-1:0] word_q, word_d;
  logic [CYC_BITS-1:0]   cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       valid_d [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];
  logic [WAYS-1:0]       dirty_d [SETS];
  tags_t                 tag_q [SETS];
  tags_t                 tag_d [SETS];
  ages_t                 age_q [SETS];
  ages_t                 age_d [SETS];
  logic [DATA_WIDTH-1:0] data_mem [WAYS][SETS][BLOCK_WORDS];

  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [OFFSET_BITS-1:0] req_off, mem_off;
  logic                   hit, inv_found, word_done, block_done, mem_we;
  logic [AGE_BITS-1:0]    hit_way, inv_way, lru_victim, victim_way;
  ages_t                  lru_age;
  logic [DATA_WIDTH-1:0]  rd_word, mem_wdat;
  logic                   rdy, mstrb, sd_wr;
  logic [ADDR_WIDTH-1:0]  sd_addr;
  logic [DATA_WIDTH-1:0]  sd_dat;

  assign req_tag    = addr_q[ADDR_WIDTH-1 -: TAG_BITS];
  assign req_idx    = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign req_off    = addr_q[OFFSET_BITS-1:0];
  assign mem_off    = (state_q == ST_ACCESS) ? req_off : word_q;
  assign rd_word    = data_mem[way_q][req_idx][mem_off];
  assign word_done  = (cyc_q == LAT_C);
  assign block_done = word_done && (word_q == '1);
  assign victim_way = inv_found ? inv_way : lru_victim;

  cache_lru #(.WAYS(WAYS), .AGE_BITS(AGE_BITS)) u_lru (
    .age_i    (age_q[req_idx]),
    .way_i    (way_q),
    .age_o    (lru_age),
    .victim_o (lru_victim)
  );

  // Descending scan so the lowest-numbered matching / invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_BITS'(w);
      end
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = AGE_BITS'(w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdat_q     <= '0;
      din_q      <= '0;
      way_q      <= '0;
      word_q     <= '0;
      cyc_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        tag_q[s]   <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_BITS'(w);
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdat_q     <= wdat_d;
      din_q      <= din_d;
      way_q      <= way_d;
      word_q     <= word_d;
      cyc_q      <= cyc_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
      age_q      <= age_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) data_mem[way_q][req_idx][mem_off] <= mem_wdat;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (bus.cs_cpu) state_d = ST_LOOKUP;
      ST_LOOKUP:    state_d = hit ? ST_ACCESS :
                              (dirty_q[req_idx][victim_way] ? ST_WRITEBACK : ST_FILL);
      ST_WRITEBACK: if (block_done) state_d = ST_FILL;
      ST_FILL:      if (block_done) state_d = ST_ACCESS;
      ST_ACCESS:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdat_d     = wdat_q;
    din_d      = din_q;
    way_d      = way_q;
    word_d     = word_q;
    cyc_d      = cyc_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    age_d      = age_q;
    mem_we     = 1'b0;
    mem_wdat   = bus.DOut_sdram;
    unique case (state_q)
      ST_IDLE: if (bus.cs_cpu) begin
        addr_d = bus.Address_cpu;
        wr_d   = bus.wr_rd_cpu;
        wdat_d = bus.DOut_cpu;
      end
      ST_LOOKUP: begin
        word_d = '0;
        cyc_d  = '0;
        if (hit) begin
          way_d = hit_way;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
        end else begin
          way_d = victim_way;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_WRITEBACK, ST_FILL: begin
        cyc_d = word_done ? '0 : cyc_q + CYC_BITS'(1);
        if (word_done) word_d = word_q + OFFSET_BITS'(1);
        if ((state_q == ST_FILL) && word_done) mem_we = 1'b1;
        if ((state_q == ST_FILL) && block_done) begin
          valid_d[req_idx][way_q] = 1'b1;
          dirty_d[req_idx][way_q] = 1'b0;
          tag_d[req_idx][way_q]   = req_tag;
        end
      end
      ST_ACCESS: begin
        age_d[req_idx] = lru_age;
        if (wr_q) begin
          mem_we                  = 1'b1;
          mem_wdat                = wdat_q;
          dirty_d[req_idx][way_q] = 1'b1;
        end else begin
          din_d = rd_word;
        end
      end
      default: ;
    endcase
  end

  // Word strobe fires on the first cycle of each SDRAM_LAT+1 cycle word slot.
  always_comb begin
    rdy     = (state_q == ST_IDLE);
    mstrb   = 1'b0;
    sd_wr   = 1'b0;
    sd_addr = '0;
    sd_dat  = '0;
    if (state_q == ST_WRITEBACK) begin
      mstrb   = (cyc_q == '0);
      sd_wr   = 1'b1;
      sd_addr = {tag_q[req_idx][way_q], req_idx, word_q};
      sd_dat  = rd_word;
    end else if (state_q == ST_FILL) begin
      mstrb   = (cyc_q == '0);
      sd_addr = {req_tag, req_idx, word_q};
    end
  end

  assign bus.rdy_cpu       = rdy;
  assign bus.din_cpu       = din_q;
  assign bus.mstrb_sdram   = mstrb;
  assign bus.wr_rd_sdram   = sd_wr;
  assign bus.Address_sdram = sd_addr;
  assign bus.din_sdram     = sd_dat;
  assign hit_cnt           = hit_cnt_q;
  assign miss_cnt          = miss_cnt_q;
endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Directed bench for cache_assoc_ctrl: SDRAM model returns the low address byte and keeps written words.
// Counters run at 2 bits so saturation shows up inside the main request table.
module tb_cache_assoc_ctrl;
  localparam int LAT = 2;

  logic clk;
  logic rst;
  logic [1:0] hit_cnt, miss_cnt;

  cache_assoc_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  cache_assoc_ctrl #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .OFFSET_BITS(5), .INDEX_BITS(3),
    .WAYS(2), .SDRAM_LAT(LAT), .CNT_WIDTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SDRAM model: data is only presented in the cycle exactly LAT cycles after a read strobe.
  bit [7:0]    sd_mem [int];
  logic [15:0] lg_addr [$];
  logic        lg_wr   [$];
  int          since;
  logic [15:0] sd_a;

  function automatic logic [7:0] sd_val(input logic [15:0] a);
    if (sd_mem.exists(int'(a))) return sd_mem[int'(a)];
    return a[7:0];
  endfunction

  always @(posedge clk) begin
    int          nxt;
    logic [15:0] a;
    a   = sd_a;
    nxt = (since < 1000) ? since + 1 : since;
    if (bus.mstrb_sdram === 1'b1) begin
      lg_addr.push_back(bus.Address_sdram);
      lg_wr.push_back(bus.wr_rd_sdram);
      if (bus.wr_rd_sdram) sd_mem[int'(bus.Address_sdram)] = bus.din_sdram;
      a   = bus.Address_sdram;
      nxt = 1;
    end
    since <= nxt;
    sd_a  <= a;
    bus.DOut_sdram <= (nxt == LAT) ? sd_val(a) : 8'hEE;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdat;
    int          low;
    logic [7:0]  din;
    int          n_rd;
    int          n_wr;
    logic [15:0] rd_base;
    logic [15:0] wr_base;
    int          hits;
    int          misses;
  } vec_t;

  vec_t vt [9];

  task automatic do_req(input logic wr, input logic [15:0] a, input logic [7:0] d, output int low);
    @(negedge clk);
    bus.cs_cpu      = 1'b1;
    bus.wr_rd_cpu   = wr;
    bus.Address_cpu = a;
    bus.DOut_cpu    = d;
    @(negedge clk);
    bus.cs_cpu = 1'b0;
    low = 0;
    while (bus.rdy_cpu !== 1'b1 && low < 1000) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic check_burst(input int i, input int start, input vec_t v);
    int nr = 0;
    int nw = 0;
    bit ord_ok = 1'b1;
    bit addr_ok = 1'b1;
    for (int k = start; k < lg_addr.size(); k++) begin
      if (lg_wr[k]) begin
        if (nr != 0) ord_ok = 1'b0;
        if (lg_addr[k] != v.wr_base + 16'(nw)) addr_ok = 1'b0;
        nw++;
      end else begin
        if (lg_addr[k] != v.rd_base + 16'(nr)) addr_ok = 1'b0;
        nr++;
      end
    end
    chk($sformatf("v%0d_rd_strobes", i), nr, v.n_rd);
    chk($sformatf("v%0d_wr_strobes", i), nw, v.n_wr);
    chk($sformatf("v%0d_strobe_addrs", i), addr_ok, 1);
    chk($sformatf("v%0d_wb_before_fill", i), ord_ok, 1);
  endtask

  initial begin
    int low, n0, k, hi;

    vt[0] = '{1'b0, 16'h1234, 8'h00,  98, 8'h34, 32,  0, 16'h1220, 16'h0000, 0, 1};
    vt[1] = '{1'b0, 16'h1235, 8'h00,   2, 8'h35,  0,  0, 16'h0000, 16'h0000, 1, 1};
    vt[2] = '{1'b1, 16'h1234, 8'hAB,   2, 8'h35,  0,  0, 16'h0000, 16'h0000, 2, 1};
    vt[3] = '{1'b0, 16'h5634, 8'h00,  98, 8'h34, 32,  0, 16'h5620, 16'h0000, 2, 2};
    vt[4] = '{1'b0, 16'h9A34, 8'h00, 194, 8'h34, 32, 32, 16'h9A20, 16'h1220, 2, 3};
    vt[5] = '{1'b0, 16'h5634, 8'h00,   2, 8'h34,  0,  0, 16'h0000, 16'h0000, 3, 3};
    vt[6] = '{1'b0, 16'h1234, 8'h00,  98, 8'hAB, 32,  0, 16'h1220, 16'h0000, 3, 3};
    vt[7] = '{1'b0, 16'h5634, 8'h00,   2, 8'h34,  0,  0, 16'h0000, 16'h0000, 3, 3};
    vt[8] = '{1'b0, 16'h9A34, 8'h00,  98, 8'h34, 32,  0, 16'h9A20, 16'h0000, 3, 3};

    rst             = 1'b0;
    bus.cs_cpu      = 1'b0;
    bus.wr_rd_cpu   = 1'b0;
    bus.Address_cpu = '0;
    bus.DOut_cpu    = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy_cpu",       bus.rdy_cpu, 1);
    chk("rst_din_cpu",       bus.din_cpu, 0);
    chk("rst_mstrb_sdram",   bus.mstrb_sdram, 0);
    chk("rst_address_sdram", bus.Address_sdram, 0);
    chk("rst_wr_rd_sdram",   bus.wr_rd_sdram, 0);
    chk("rst_din_sdram",     bus.din_sdram, 0);
    chk("rst_hit_cnt",       hit_cnt, 0);
    chk("rst_miss_cnt",      miss_cnt, 0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      n0 = lg_addr.size();
      do_req(vt[i].wr, vt[i].addr, vt[i].wdat, low);
      chk($sformatf("v%0d_rdy_low", i), low, vt[i].low);
      chk($sformatf("v%0d_din_cpu", i), bus.din_cpu, vt[i].din);
      chk($sformatf("v%0d_hit_cnt", i), hit_cnt, vt[i].hits);
      chk($sformatf("v%0d_miss_cnt", i), miss_cnt, vt[i].misses);
      check_burst(i, n0, vt[i]);
    end
    chk("wb_data_1234", sd_val(16'h1234), 8'hAB);
    chk("wb_data_1235", sd_val(16'h1235), 8'h35);
    chk("wb_data_123f", sd_val(16'h123F), 8'h3F);

    // Reset asserted while the 10th fill strobe is on the bus.
    @(negedge clk);
    bus.cs_cpu      = 1'b1;
    bus.wr_rd_cpu   = 1'b0;
    bus.Address_cpu = 16'h7734;
    @(negedge clk);
    bus.cs_cpu = 1'b0;
    n0 = lg_addr.size();
    k  = 0;
    while (!(bus.mstrb_sdram === 1'b1 && lg_addr.size() - n0 == 9) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("midrst_reached_10th_strobe", (k < 1000), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_mstrb_sdram", bus.mstrb_sdram, 0);
    chk("midrst_rdy_cpu",     bus.rdy_cpu, 1);
    chk("midrst_miss_cnt",    miss_cnt, 0);
    chk("midrst_hit_cnt",     hit_cnt, 0);
    rst = 1'b1;
    n0  = lg_addr.size();
    repeat (8) @(negedge clk);
    chk("midrst_no_more_strobes", lg_addr.size() - n0, 0);
    n0 = lg_addr.size();
    do_req(1'b0, 16'h1234, 8'h00, low);
    chk("reread_rdy_low",  low, 98);
    chk("reread_strobes",  lg_addr.size() - n0, 32);
    chk("reread_din_cpu",  bus.din_cpu, 8'hAB);
    chk("reread_miss_cnt", miss_cnt, 1);
    chk("reread_hit_cnt",  hit_cnt, 0);

    // cs_cpu held high: one miss, one idle cycle, then the same address hits.
    @(negedge clk);
    bus.cs_cpu      = 1'b1;
    bus.wr_rd_cpu   = 1'b0;
    bus.Address_cpu = 16'hC034;
    @(negedge clk);
    low = 0;
    while (bus.rdy_cpu !== 1'b1 && low < 1000) begin
      low++;
      @(negedge clk);
    end
    chk("held_miss_rdy_low", low, 98);
    hi = 0;
    while (bus.rdy_cpu === 1'b1 && hi < 10) begin
      hi++;
      @(negedge clk);
    end
    chk("held_rdy_high_cycles", hi, 1);
    bus.cs_cpu = 1'b0;
    low = 0;
    while (bus.rdy_cpu !== 1'b1 && low < 1000) begin
      low++;
      @(negedge clk);
    end
    chk("held_hit_rdy_low", low, 2);
    chk("held_din_cpu",     bus.din_cpu, 8'h34);
    chk("held_miss_cnt",    miss_cnt, 2);
    chk("held_hit_cnt",     hit_cnt, 1);
    repeat (5) @(negedge clk);
    chk("held_idle_after", bus.rdy_cpu, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_assoc_ctrl.md
Name: cache_assoc_ctrl

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache with internal data, tag, valid and dirty arrays and LRU replacement.
- Sits between the CPU (cs/wr_rd/rdy handshake) and the SDRAM (mstrb word-strobe interface).
- Successor to the direct-mapped controller/SRAM pair: configurable geometry, true LRU, hit and miss counters.

Parameters:
ADDR_WIDTH, 16, CPU/SDRAM address width
DATA_WIDTH, 8, word width
OFFSET_BITS, 5, log2 words per block (32-word blocks)
INDEX_BITS, 3, log2 sets
WAYS, 2, associativity; legal values 1, 2, 4
SDRAM_LAT, 2, cycles from mstrb_sdram pulse to word completion (minimum 1)
CNT_WIDTH, 16, hit/miss counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
Address_cpu  in  ADDR_WIDTH  CPU address
wr_rd_cpu  in  1  1 = write, 0 = read
cs_cpu  in  1  request strobe
DOut_cpu  in  DATA_WIDTH  CPU write data
din_cpu  out  DATA_WIDTH  read data to CPU, registered
rdy_cpu  out  1  1 = idle and ready to accept
Address_sdram  out  ADDR_WIDTH  SDRAM word address
wr_rd_sdram  out  1  1 = write, 0 = read
mstrb_sdram  out  1  one-cycle word strobe
din_sdram  out  DATA_WIDTH  write data to SDRAM
DOut_sdram  in  DATA_WIDTH  read data from SDRAM
hit_cnt  out  CNT_WIDTH  saturating hit count
miss_cnt  out  CNT_WIDTH  saturating miss count

Behaviour:
- Reset is synchronous: rst sampled low at a rising edge of clk. On reset:
  - FSM goes to IDLE; all valid and dirty bits clear; per-set LRU ages set to age[w] = w.
  - Outputs: rdy_cpu = 1; din_cpu, Address_sdram, wr_rd_sdram, mstrb_sdram, din_sdram, hit_cnt, miss_cnt all = 0.
  - Data array contents are don't-care.
- Address split: tag = [ADDR_WIDTH-1 : INDEX_BITS+OFFSET_BITS], index = next INDEX_BITS, offset = low OFFSET_BITS.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL, ACCESS.
- IDLE:
  - cs_cpu = 1 at an edge latches address, wr_rd and data; next state LOOKUP; rdy_cpu = 0 from the following cycle.
  - cs_cpu is ignored whenever rdy_cpu = 0.
- LOOKUP: compare the tag against all valid ways of the set.
  - Hit → ACCESS; hit_cnt increments.
  - Miss → miss_cnt increments. Victim is the lowest-numbered invalid way; otherwise the way whose age = WAYS-1. Victim dirty → WRITEBACK; else FILL.
- SDRAM word transfer:
  - mstrb_sdram is high for 1 cycle, with Address_sdram, wr_rd_sdram and din_sdram valid in that cycle.
  - On reads, DOut_sdram is sampled SDRAM_LAT cycles after the strobe.
  - The next strobe follows on the cycle after completion, so each word costs SDRAM_LAT+1 cycles.
- WRITEBACK:
  - Transfers 2^OFFSET_BITS words, offset 0 upward, Address_sdram = {victim tag, index, offset}.
  - Then FILL. The dirty bit clears when the victim tag is replaced.
- FILL:
  - Reads 2^OFFSET_BITS words into the victim way, Address_sdram = {req tag, index, offset}.
  - Then sets valid = 1, dirty = 0, writes the new tag, and moves to ACCESS.
- ACCESS (one cycle):
  - Read: din_cpu ← word.
  - Write: word ← latched data; dirty = 1.
  - LRU update: accessed way age → 0; ways with age < its old age increment.
  - rdy_cpu = 1 at the end; next state IDLE.
- rdy_cpu low duration:
  - Hit: exactly 2 cycles.
  - Clean miss: 2 + B·(SDRAM_LAT+1).
  - Dirty miss: 2 + 2·B·(SDRAM_LAT+1), where B = 2^OFFSET_BITS.
  - Defaults: 2, 98, 194.
- mstrb_sdram = 0 in IDLE, LOOKUP and ACCESS. din_cpu holds its value until the next read ACCESS.
- Counters saturate at all-ones; a hit and a miss never occur in the same cycle.
- Reset mid-burst: the burst aborts at the reset edge with no further strobes, and the cache is empty afterwards.

Decomposition:
- Package cache_pkg holds:
  - FSM state encoding;
  - derived localparams: TAG_BITS = ADDR_WIDTH-INDEX_BITS-OFFSET_BITS, BLOCK_WORDS, SETS, AGE_BITS = max(1, log2 WAYS);
  - legal-WAYS check.
- Sub-module cache_lru, purely combinational:
  - inputs: per-set age vector, accessed way;
  - outputs: updated ages, victim way.

Test Plan (defaults; SDRAM model returns low byte of address, stores writes):
1. Reset, read 0x1234 → 32 read strobes 0x1220..0x123F, rdy_cpu low 98 cycles, din_cpu = 0x34, miss_cnt = 1.
2. Then read 0x1235 → no strobes, rdy_cpu low 2 cycles, din_cpu = 0x35, hit_cnt = 1.
3. Then:
   - write 0xAB @0x1234 (hit, way0 dirty);
   - read 0x5634 → fills way1, no writeback;
   - read 0x9A34 → victim way0: 32 writes 0x1220..0x123F (word 0x1234 = 0xAB), then 32 reads 0x9A20.., rdy_cpu low 194 cycles, din_cpu = 0x34.
4. Read 0x5634 then 0x1234 → 0x5634 hits; 0x1234 misses and evicts 0x9A (LRU), not 0x56. Model memory at 0x1234 reads back 0xAB.
5. Drive rst = 0 at the 10th fill strobe → next cycle mstrb_sdram = 0, rdy_cpu = 1. Re-read 0x1234 → full miss again.
6. Hold cs_cpu = 1 throughout a miss → exactly one request serviced per rdy_cpu high cycle. With CNT_WIDTH = 2, miss_cnt saturates at 3 after 5 misses.
